// File: rtl/fp_div_pre.sv
// fp_div_pre: operand classify, subnormal normalize and issue stage for the FP divider.
// Define FP_DIV_PRE_SUBNORMAL_EN to normalize subnormals instead of flushing them to zero.
module fp_div_pre #(
  parameter int FRAC_WIDTH = 52,
  parameter int EXPO_WIDTH = 11,
  parameter int NORM_STEP  = 8,
  parameter int ID_WIDTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             ready,
  input  logic [FRAC_WIDTH+EXPO_WIDTH:0]   rs1,
  input  logic [FRAC_WIDTH+EXPO_WIDTH:0]   rs2,
  input  logic [2:0]                       rm,
  input  logic [ID_WIDTH-1:0]              id,
  output logic                             div_start,
  output logic [FRAC_WIDTH+1:0]            div_dividend,
  output logic [FRAC_WIDTH+1:0]            div_divisor,
  input  logic                             div_done,
  output logic                             meta_valid,
  output logic                             meta_sign,
  output logic [EXPO_WIDTH+1:0]            meta_expo,
  output logic [2:0]                       meta_rm,
  output logic [ID_WIDTH-1:0]              meta_id,
  output logic                             special_valid,
  output logic [FRAC_WIDTH+EXPO_WIDTH:0]   special_result,
  output logic [ID_WIDTH-1:0]              special_id,
  output logic                             special_nv,
  output logic                             special_dz
);

  localparam int XW = EXPO_WIDTH + 2;
  localparam int SW = FRAC_WIDTH + 1;
  localparam logic [XW-1:0] BIAS =
    XW'((1 << (EXPO_WIDTH - 1)) - 1);
  localparam logic [FRAC_WIDTH+EXPO_WIDTH:0] QNAN =
    {1'b0, {EXPO_WIDTH{1'b1}}, 1'b1,
     {(FRAC_WIDTH-1){1'b0}}};

`ifdef FP_DIV_PRE_SUBNORMAL_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NORM_A = 2'd1,
    NORM_B = 2'd2,
    ISSUE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd3
  } state_t;
`endif

  state_t state;
  logic   busy;

  logic [SW-1:0] sig_a;
  logic [SW-1:0] sig_b;

  logic                  s1, s2;
  logic [EXPO_WIDTH-1:0] e1, e2;
  logic [FRAC_WIDTH-1:0] f1, f2;

  assign {s1, e1, f1} = rs1;
  assign {s2, e2, f2} = rs2;

  logic ez1, ez2, fz1, fz2;
  logic emax1, emax2;
  logic nan1, nan2, snan1, snan2;
  logic inf1, inf2, zero1, zero2;

  assign ez1   = ~|e1;
  assign ez2   = ~|e2;
  assign fz1   = ~|f1;
  assign fz2   = ~|f2;
  assign emax1 = &e1;
  assign emax2 = &e2;
  assign nan1  = emax1 & ~fz1;
  assign nan2  = emax2 & ~fz2;
  assign snan1 = nan1 & ~f1[FRAC_WIDTH-1];
  assign snan2 = nan2 & ~f2[FRAC_WIDTH-1];
  assign inf1  = emax1 & fz1;
  assign inf2  = emax2 & fz2;

`ifdef FP_DIV_PRE_SUBNORMAL_EN
  logic sub1, sub2;
  assign zero1 = ez1 & fz1;
  assign zero2 = ez2 & fz2;
  assign sub1  = ez1 & ~fz1;
  assign sub2  = ez2 & ~fz2;
`else
  // subnormals flush to signed zero here
  assign zero1 = ez1;
  assign zero2 = ez2;
`endif

  logic [XW-1:0] ea_in, eb_in;
  assign ea_in = ez1 ? XW'(1) : {2'b00, e1};
  assign eb_in = ez2 ? XW'(1) : {2'b00, e2};

  logic                          is_sp;
  logic                          sp_nv, sp_dz;
  logic [FRAC_WIDTH+EXPO_WIDTH:0] sp_res;
  logic                          sgn;

  assign sgn   = s1 ^ s2;
  assign is_sp = nan1 | nan2 | inf1 | inf2
               | zero1 | zero2;

  always_comb begin
    sp_res = '0;
    sp_nv  = 1'b0;
    sp_dz  = 1'b0;
    if (snan1 | snan2 | (zero1 & zero2)
        | (inf1 & inf2)) begin
      sp_res = QNAN;
      sp_nv  = 1'b1;
    end else if (nan1 | nan2) begin
      sp_res = QNAN;
    end else if (zero2 & ~inf1) begin
      sp_res = {sgn, {EXPO_WIDTH{1'b1}},
                {FRAC_WIDTH{1'b0}}};
      sp_dz  = 1'b1;
    end else if (inf1) begin
      sp_res = {sgn, {EXPO_WIDTH{1'b1}},
                {FRAC_WIDTH{1'b0}}};
    end else begin
      sp_res = {sgn, {(FRAC_WIDTH+EXPO_WIDTH){1'b0}}};
    end
  end

`ifdef FP_DIV_PRE_SUBNORMAL_EN
  logic [XW-1:0]        exp_a, exp_b;
  logic                 sub_b;
  logic [SW-1:0]        n_in, n_sig;
  logic [XW-1:0]        n_exp_in, n_exp, n_sh;
  logic [NORM_STEP-1:0] n_top;

  // shift by a full step, or by the leading-zero count of the top window
  always_comb begin
    n_in     = (state == NORM_B) ? sig_b : sig_a;
    n_exp_in = (state == NORM_B) ? exp_b : exp_a;
    n_top    = n_in[SW-1 -: NORM_STEP];
    n_sh     = XW'(NORM_STEP);
    for (int i = 0; i < NORM_STEP; i++)
      if (n_top[i]) n_sh = XW'(NORM_STEP - 1 - i);
    n_sig = n_in << n_sh;
    n_exp = n_exp_in - n_sh;
  end
`endif

  assign ready        = (state == IDLE);
  assign div_start    = (state == ISSUE)
                      & (~busy | div_done);
  assign meta_valid   = div_start;
  assign div_dividend = {1'b0, sig_a};
  assign div_divisor  = {1'b0, sig_b};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      sig_a          <= '0;
      sig_b          <= '0;
      meta_sign      <= 1'b0;
      meta_expo      <= '0;
      meta_rm        <= '0;
      meta_id        <= '0;
      special_valid  <= 1'b0;
      special_result <= '0;
      special_id     <= '0;
      special_nv     <= 1'b0;
      special_dz     <= 1'b0;
`ifdef FP_DIV_PRE_SUBNORMAL_EN
      exp_a          <= '0;
      exp_b          <= '0;
      sub_b          <= 1'b0;
`endif
    end else begin
      special_valid <= 1'b0;
      special_nv    <= 1'b0;
      special_dz    <= 1'b0;
      if (div_start)     busy <= 1'b1;
      else if (div_done) busy <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && is_sp) begin
            special_valid  <= 1'b1;
            special_result <= sp_res;
            special_nv     <= sp_nv;
            special_dz     <= sp_dz;
            special_id     <= id;
          end else if (start) begin
            meta_sign <= sgn;
            meta_rm   <= rm;
            meta_id   <= id;
            sig_a     <= {~ez1, f1};
            sig_b     <= {~ez2, f2};
`ifdef FP_DIV_PRE_SUBNORMAL_EN
            exp_a <= ea_in;
            exp_b <= eb_in;
            sub_b <= sub2;
            if (sub1) begin
              state <= NORM_A;
            end else if (sub2) begin
              state <= NORM_B;
            end else begin
              state     <= ISSUE;
              meta_expo <= ea_in - eb_in + BIAS;
            end
`else
            state     <= ISSUE;
            meta_expo <= ea_in - eb_in + BIAS;
`endif
          end
        end
`ifdef FP_DIV_PRE_SUBNORMAL_EN
        NORM_A: begin
          sig_a <= n_sig;
          exp_a <= n_exp;
          if (n_sig[SW-1]) begin
            if (sub_b) begin
              state <= NORM_B;
            end else begin
              state     <= ISSUE;
              meta_expo <= n_exp - exp_b + BIAS;
            end
          end
        end
        NORM_B: begin
          sig_b <= n_sig;
          exp_b <= n_exp;
          if (n_sig[SW-1]) begin
            state     <= ISSUE;
            meta_expo <= exp_a - n_exp + BIAS;
          end
        end
`endif
        ISSUE: begin
          if (div_start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_div_pre.md
# fp_div_pre

Operand pre-processing and issue stage directly upstream of the radix-4 FP divider core. It accepts two IEEE-754 operands and classifies them. Special cases (NaN, infinity, zero, divide-by-zero) are resolved without using the divider. Subnormal significands are normalized over multiple cycles. Normal operations issue a one-cycle `div_start` with aligned significands, and the sign/exponent/rounding metadata goes to the post-divide normalization stage.

## Interface
- `FRAC_WIDTH`, 52: stored fraction bits.
- `EXPO_WIDTH`, 11: exponent field bits. `FLEN = 1+EXPO_WIDTH+FRAC_WIDTH`; `DIV_WIDTH = FRAC_WIDTH+2`.
- `NORM_STEP`, 8: maximum left-shift per normalization cycle (power of two, ≤ FRAC_WIDTH).
- `ID_WIDTH`, 4: instruction tag width.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  operation request.
- `ready`  out  1  request accepted when `start & ready`.
- `rs1`, `rs2`  in  FLEN  dividend, divisor.
- `rm`  in  3  rounding mode, passed through.
- `id`  in  ID_WIDTH  tag, passed through.
- `div_start`  out  1  one-cycle issue pulse to divider.
- `div_dividend`, `div_divisor`  out  DIV_WIDTH  significands `{2'b01, frac}`.
- `div_done`  in  1  divider completion pulse.
- `meta_valid`  out  1  asserted with `div_start`.
- `meta_sign`  out  1  `sign1 ^ sign2`.
- `meta_expo`  out  EXPO_WIDTH+2  signed biased result exponent.
- `meta_rm`, `meta_id`  out  3/ID_WIDTH  pass-through.
- `special_valid`  out  1  one-cycle special-result pulse.
- `special_result`  out  FLEN  final result.
- `special_id`  out  ID_WIDTH  tag.
- `special_nv`, `special_dz`  out  1  invalid / divide-by-zero flags.

## Operation
- FSM states: IDLE, NORM_A, NORM_B, ISSUE.
- IDLE: `ready=1`. On accept, register operands, rm and id, and classify.
  - Special operand → emit special next cycle, stay IDLE.
  - Else a subnormal operand exists → NORM_A (if rs1 subnormal) or NORM_B.
  - Else → ISSUE.
- Special priority:
  - Either operand is sNaN, or 0/0, or inf/inf → canonical NaN `0x7FF8…0`, nv=1.
  - Either operand is qNaN → canonical NaN, nv=0.
  - x/0 with x finite nonzero → ±inf, dz=1.
  - inf/x → ±inf.
  - 0/x or x/inf → ±0.
  - Sign of ±results = `meta_sign`.
- NORM_x: working significand starts as `{1'b0, frac}` with exponent 1.
  - If the top NORM_STEP bits are zero, shift left NORM_STEP and subtract NORM_STEP from the exponent.
  - Else shift by the leading-zero count within those bits, finishing with the hidden bit set. Then go to NORM_B (if rs2 subnormal) or ISSUE.
- Exponent: `meta_expo = e1 - e2 + bias`, computed signed in EXPO_WIDTH+2 bits, using the post-normalization exponents. No clamping; over/underflow is handled downstream.
- ISSUE: issue allowed when `!busy | div_done`. Assert `div_start` and `meta_valid` combinationally, then go to IDLE.
- `busy` flag:
  - Set on `div_start`.
  - Cleared on `div_done` without `div_start`.
  - `div_start` together with `div_done` leaves `busy` set.
- `ready` is low outside IDLE. A new op may be accepted and preprocessed while the divider is busy; it then waits in ISSUE.

## Timing
- Reset values: state IDLE, `busy=0`, `ready=1`. `div_start`, `meta_valid`, `special_valid`, `special_nv`, `special_dz` all 0. All data outputs 0.
- Normal operands with divider idle: accept in cycle 0, `div_start` in cycle 1.
- Special: accept in cycle 0, `special_valid` in cycle 1. `ready` stays high in cycle 1, so back-to-back specials issue one per cycle.
- Subnormal: adds `ceil(lz/NORM_STEP)` cycles per subnormal operand (minimum 1).
- `div_dividend`, `div_divisor` and `meta_*` are held stable from ISSUE entry until `div_start`.
- Reset asserted mid-operation clears everything immediately, including `busy`. Any in-flight divider result is the system's responsibility.

## Configuration
- `FP_DIV_PRE_SUBNORMAL_EN` defined: NORM_A/NORM_B are present and subnormals are normalized as above.
- Not defined: NORM states are not compiled. Subnormal inputs are treated as signed zero for classification (flush-to-zero), and no flags are raised for the flush.

## Test plan
- rs1=`0x3FF8000000000000`, rs2=`0x3FF0000000000000`, divider idle → `div_start` cycle 1, dividend `{2'b01,0x8000000000000}`, divisor `{2'b01,0}`, meta_expo=1023, sign=0.
- rs1=`0xBFF0000000000000`, rs2=`0x0000000000000000` → special_valid cycle 1, result `0xFFF0000000000000`, dz=1, nv=0, no `div_start`.
- rs1=rs2=`0x0000000000000000` → result `0x7FF8000000000000`, nv=1, dz=0; rs1=`0x7FF0000000000000` with rs2=`0x7FF0000000000000` → same response.
- rs1=`0x0000000000000001`, rs2=`0x3FF0000000000000` with SUBNORMAL_EN → 7 NORM_A cycles, dividend `{2'b01,52'b0}`, meta_expo=−51; without the macro → special +0.
- Two normal ops back-to-back; `div_done` held low 30 cycles → second op waits in ISSUE with `ready=0`. Its `div_start` fires in the `div_done` cycle and `busy` stays 1.
- rst low during NORM_A → next cycle IDLE, `ready=1`, `busy=0`, all pulses 0; a fresh op then issues normally.
